// File: rtl/dso_pkg.sv
// rtl/dso_pkg.sv - shared types and default sizes for the capture path
package dso_pkg;

    localparam int DEFAULT_DEPTH  = 512;
    localparam int DEFAULT_ADDR_W = 9;

    typedef logic [DEFAULT_ADDR_W-1:0] trig_pos_t;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        POST,
        DONE
    } capture_state_t;

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - enabled up-counter wrapping naturally at 2**W
module wrap_counter #(
    parameter int W = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - capture sequencer: circular write pointer, arm/trigger handshake, post-trigger count
module capture_ctrl
    import dso_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              sample_valid,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              triggered,
    output logic              trig_en,
    output logic              armed,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic              set_capture_done,
    output logic              capture_done,
    output logic [ADDR_W-1:0] start_addr
);

    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    capture_state_t    state_q;
    logic [ADDR_W:0]   pre_cnt_q, pre_cnt_d, need_cnt;
    logic [ADDR_W-1:0] post_cnt_q, wptr;
    logic [ADDR_W-1:0] waddr_q, start_addr_q;
    logic              trig_en_q, armed_q, we_q, set_done_q, capture_done_q;
    logic              post_full, wr_fire;

    // Pre-trigger samples needed so that pre + trig_pos fills the whole buffer.
    assign need_cnt  = FULL - {1'b0, trig_pos};
    assign post_full = (post_cnt_q == trig_pos);
    assign wr_fire   = sample_valid && !abort &&
                       ((state_q == PRE) || ((state_q == POST) && !post_full));

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (sample_valid && (pre_cnt_q != FULL)) begin
            pre_cnt_d = pre_cnt_q + 1'b1;
        end
    end

    wrap_counter #(.W(ADDR_W)) u_wptr (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (wr_fire),
        .count_o (wptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            pre_cnt_q      <= '0;
            post_cnt_q     <= '0;
            trig_en_q      <= 1'b0;
            armed_q        <= 1'b0;
            we_q           <= 1'b0;
            waddr_q        <= '0;
            set_done_q     <= 1'b0;
            capture_done_q <= 1'b0;
            start_addr_q   <= '0;
        end else begin
            we_q       <= wr_fire;
            set_done_q <= 1'b0;
            if (wr_fire) begin
                waddr_q <= wptr;
            end
            case (state_q)
                IDLE, DONE: begin
                    if (start && !abort) begin
                        state_q        <= PRE;
                        pre_cnt_q      <= '0;
                        post_cnt_q     <= '0;
                        capture_done_q <= 1'b0;
                        trig_en_q      <= 1'b1;
                        armed_q        <= 1'b0;
                    end
                end
                PRE: begin
                    if (abort) begin
                        state_q    <= IDLE;
                        trig_en_q  <= 1'b0;
                        armed_q    <= 1'b0;
                        set_done_q <= 1'b1;
                    end else begin
                        pre_cnt_q <= pre_cnt_d;
                        armed_q   <= !triggered && (pre_cnt_d >= need_cnt);
                        if (triggered) begin
                            state_q    <= POST;
                            post_cnt_q <= '0;
                        end
                    end
                end
                POST: begin
                    if (abort) begin
                        state_q    <= IDLE;
                        trig_en_q  <= 1'b0;
                        armed_q    <= 1'b0;
                        set_done_q <= 1'b1;
                    end else if (post_full) begin
                        // wptr now points at the oldest of DEPTH consecutive samples.
                        state_q        <= DONE;
                        trig_en_q      <= 1'b0;
                        armed_q        <= 1'b0;
                        set_done_q     <= 1'b1;
                        capture_done_q <= 1'b1;
                        start_addr_q   <= wptr;
                    end else if (sample_valid) begin
                        post_cnt_q <= post_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign trig_en          = trig_en_q;
    assign armed            = armed_q;
    assign we               = we_q;
    assign waddr            = waddr_q;
    assign set_capture_done = set_done_q;
    assign capture_done     = capture_done_q;
    assign start_addr       = start_addr_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb/tb_capture_ctrl.sv - directed bench for capture_ctrl with write-address scoreboard
module tb_capture_ctrl;
    import dso_pkg::*;

    logic      clk = 1'b0;
    logic      rst, start, abort, sample_valid, triggered;
    trig_pos_t trig_pos;
    logic      trig_en, armed, we, set_capture_done, capture_done;
    logic [8:0] waddr, start_addr;

    int errors = 0;
    int checks = 0;

    capture_state_t m_state;
    int  m_pre, m_post, m_wptr, m_sa, tp;
    bit  m_cd, m_ten, m_armed, exp_we, exp_sd, trg_q;
    int  sb_q[$];
    int  seg_we, seg_sd;

    capture_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .sample_valid     (sample_valid),
        .trig_pos         (trig_pos),
        .triggered        (triggered),
        .trig_en          (trig_en),
        .armed            (armed),
        .we               (we),
        .waddr            (waddr),
        .set_capture_done (set_capture_done),
        .capture_done     (capture_done),
        .start_addr       (start_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = IDLE; m_pre = 0; m_post = 0; m_wptr = 0; m_sa = 0;
        m_cd = 0; m_ten = 0; m_armed = 0; trg_q = 0;
        sb_q.delete();
    endtask

    task automatic do_reset();
        rst = 1; start = 0; abort = 0; sample_valid = 0; triggered = 0;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_armed", armed, 0);
        chk("rst_trig_en", trig_en, 0);
        chk("rst_set_done", set_capture_done, 0);
        chk("rst_capture_done", capture_done, 0);
        chk("rst_start_addr", start_addr, 0);
    endtask

    // One clock: drive inputs, advance the reference model, compare after the edge,
    // then update the trigger-stage SR flop model.
    task automatic cycle(input bit sv, input bit st, input bit ab, input bit cond);
        int exp_a;
        sample_valid = sv; start = st; abort = ab; triggered = trg_q;
        exp_we = 0; exp_sd = 0;
        case (m_state)
            IDLE, DONE: if (st && !ab) begin
                m_state = PRE; m_pre = 0; m_post = 0; m_cd = 0; m_ten = 1;
            end
            PRE: if (ab) begin
                m_state = IDLE; m_ten = 0; exp_sd = 1;
            end else begin
                if (sv) begin exp_we = 1; if (m_pre < 512) m_pre++; end
                if (trg_q) begin m_state = POST; m_post = 0; end
            end
            POST: if (ab) begin
                m_state = IDLE; m_ten = 0; exp_sd = 1;
            end else if (m_post == tp) begin
                m_state = DONE; m_ten = 0; m_cd = 1; m_sa = m_wptr; exp_sd = 1;
            end else if (sv) begin
                exp_we = 1; m_post++;
            end
            default: ;
        endcase
        if (exp_we) begin
            sb_q.push_back(m_wptr);
            m_wptr = (m_wptr + 1) % 512;
        end
        m_armed = (m_state == PRE) && (m_pre >= 512 - tp);

        @(posedge clk); #1;
        if (we === 1'b1) begin
            seg_we++;
            chk("sb_nonempty", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                exp_a = sb_q.pop_front();
                chk("waddr", waddr, exp_a);
            end
        end
        chk("we", we, exp_we);
        chk("set_done", set_capture_done, exp_sd);
        chk("armed", armed, m_armed);
        chk("trig_en", trig_en, m_ten);
        chk("capture_done", capture_done, m_cd);
        chk("start_addr", start_addr, m_sa);
        if (set_capture_done === 1'b1) begin
            seg_sd++;
            trg_q = 0;
        end else if (trig_en && armed && cond) begin
            trg_q = 1;
        end
    endtask

    task automatic run_capture(input int tp_in, input int cond_from,
                               input int exp_writes, input int exp_sa);
        bit done;
        tp = tp_in; trig_pos = trig_pos_t'(tp_in);
        seg_we = 0; seg_sd = 0; done = 0;
        cycle(0, 1, 0, 0);
        for (int i = 1; i <= 2000 && !done; i++) begin
            cycle(1, i == 300, 0, i >= cond_from);
            if (set_capture_done === 1'b1) done = 1;
        end
        chk("done_timeout", done, 1);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
        chk("cap_writes", seg_we, exp_writes);
        chk("cap_done_pulses", seg_sd, 1);
        chk("cap_done_flag", capture_done, 1);
        chk("cap_start_addr", start_addr, exp_sa);
    endtask

    initial begin
        tp = 0; trig_pos = '0; seg_we = 0; seg_sd = 0;
        do_reset();

        // trig_pos=256, trigger condition from sample 100
        run_capture(256, 100, 513, 1);

        // trig_pos=0, trigger after 600 samples
        run_capture(0, 600, 601, 90);

        // park wptr at 500 via an aborted capture (same-cycle sample dropped)
        tp = 0; trig_pos = '0; seg_we = 0; seg_sd = 0;
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 410; i++) cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 0);
        cycle(0, 0, 0, 0);
        chk("pre_abort_writes", seg_we, 410);
        chk("pre_abort_pulses", seg_sd, 1);
        chk("pre_abort_cd", capture_done, 0);

        // trig_pos=511 from wptr 500, wraps 511->0
        run_capture(511, 1, 513, 501);

        // abort after 10 post-trigger writes
        tp = 500; trig_pos = trig_pos_t'(tp); seg_we = 0; seg_sd = 0;
        cycle(0, 1, 0, 0);
        for (int i = 1; i <= 100; i++) begin
            cycle(1, 0, 0, 1);
            if (m_state == POST && m_post == 10) break;
        end
        cycle(1, 0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
        chk("post_abort_writes", seg_we, 23);
        chk("post_abort_pulses", seg_sd, 1);
        chk("post_abort_cd", capture_done, 0);
        chk("post_abort_trig_en", trig_en, 0);

        // abort wins over start in IDLE
        cycle(0, 1, 1, 0);
        chk("start_abort_idle", trig_en, 0);

        // reset in the middle of PRE, then a normal capture from wptr 0
        tp = 100; trig_pos = trig_pos_t'(tp);
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0);
        do_reset();
        run_capture(511, 1, 513, 1);

        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
